// File: rtl/tile_load_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tile_load_arbiter: round-robin owner of the column loader; streams one      |
// | Dim*Dim-word tile per grant, then waits for the loader or a timeout.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tile_load_arbiter #(
    parameter int Dim  = 4,
    parameter int W    = 77,
    parameter int NREQ = 2,
    parameter int TMO  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_v_i,
    input  logic [NREQ-1:0][W-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_r_o,
    output logic [W-1:0]             ld_bit_o,
    output logic                     ld_v_o,
    input  logic                     ld_r_i,
    input  logic                     ld_done_i,
    output logic                     ld_rst_o,
    output logic [NREQ-1:0]          grant_o,
    output logic                     busy_o,
    output logic [7:0]               tile_cnt_o,
    output logic                     err_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(Dim * Dim + 1);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [CW-1:0] C_LAST_WORD = CW'(Dim * Dim - 1);
    localparam logic [TW-1:0] C_TMO_LAST  = TW'(TMO - 1);
    localparam logic [PW-1:0] C_LAST_REQ  = PW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RELEASE   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_gidx;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   w_pick;
    logic [CW-1:0]   r_word_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [7:0]      r_tile_cnt;
    logic            r_err;
    logic            r_ld_rst;
    logic            w_xfer;
    logic [NREQ-1:0] w_onehot;

    // First valid requester at or above the round-robin pointer, wrapping.
    always_comb begin : p_pick
        int s;
        s      = 0;
        w_pick = r_rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = int'(r_rr_ptr) + k;
            if (s >= NREQ) begin
                s = s - NREQ;
            end
            if (req_v_i[PW'(s)]) begin
                w_pick = PW'(s);
            end
        end
    end

    assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_r_o     = '0;
        ld_v_o      = 1'b0;
        ld_bit_o    = '0;
        w_xfer      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req_v_i) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                ld_v_o           = req_v_i[r_gidx];
                req_r_o[r_gidx]  = ld_r_i;
                if (ld_v_o) begin
                    ld_bit_o = req_data_i[r_gidx];
                end
                w_xfer = ld_v_o & ld_r_i;
                if (w_xfer && (r_word_cnt == C_LAST_WORD)) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (ld_done_i || (r_tmo_cnt == C_TMO_LAST)) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Loader restart is registered so it stays high through reset and drops
    // on the first clock edge after rst_ni rises.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ld_rst   <= 1'b1;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_word_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_tile_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_ld_rst <= (w_state_nxt == S_START);
            if ((r_state == S_IDLE) && (|req_v_i)) begin
                r_gidx <= w_pick;
            end
            if (r_state == S_START) begin
                r_word_cnt <= '0;
            end else if (w_xfer) begin
                r_word_cnt <= r_word_cnt + CW'(1);
            end
            if (r_state == S_WAIT_DONE) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if ((r_state == S_WAIT_DONE) && !ld_done_i && (r_tmo_cnt == C_TMO_LAST)) begin
                r_err <= 1'b1;
            end
            if (r_state == S_RELEASE) begin
                r_tile_cnt <= r_tile_cnt + 8'd1;
                r_rr_ptr   <= (r_gidx == C_LAST_REQ) ? '0 : r_gidx + PW'(1);
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if ((r_state == S_START) || (r_state == S_STREAM) || (r_state == S_WAIT_DONE)) begin
            grant_o = w_onehot;
        end
    end

    assign busy_o     = (r_state != S_IDLE);
    assign ld_rst_o   = r_ld_rst;
    assign tile_cnt_o = r_tile_cnt;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tile_load_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tile_load_arbiter: tile-level model of the arbiter compared every cycle,|
// | plus directed scenarios with hand-computed expectations.  Revision: 1.0    |
// +----------------------------------------------------------------------------+
module tb_tile_load_arbiter;

    localparam int DIM  = 4;
    localparam int WD   = 77;
    localparam int NR   = 2;
    localparam int TO   = 64;
    localparam int TILE = DIM * DIM;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [NR-1:0]         req_v_i;
    logic [NR-1:0][WD-1:0] req_data_i;
    logic [NR-1:0]         req_r_o;
    logic [WD-1:0]         ld_bit_o;
    logic                  ld_v_o;
    logic                  ld_r_i;
    logic                  ld_done_i;
    logic                  ld_rst_o;
    logic [NR-1:0]         grant_o;
    logic                  busy_o;
    logic [7:0]            tile_cnt_o;
    logic                  err_o;

    tile_load_arbiter #(.Dim(DIM), .W(WD), .NREQ(NR), .TMO(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_v_i(req_v_i), .req_data_i(req_data_i),
        .req_r_o(req_r_o), .ld_bit_o(ld_bit_o), .ld_v_o(ld_v_o), .ld_r_i(ld_r_i),
        .ld_done_i(ld_done_i), .ld_rst_o(ld_rst_o), .grant_o(grant_o), .busy_o(busy_o),
        .tile_cnt_o(tile_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Stimulus sources: requester r offers words pat(r,k) for k < src_limit[r].
    int            src_word[NR];
    int            src_limit[NR];
    bit            gap_on     = 1'b0;
    int            ldr_mode   = 0;
    int            done_delay = 0;
    bit            spurious   = 1'b0;
    logic [NR-1:0] hs = '0;
    int            cyc = 0;

    // Tile-level model: owner (-1 none), words still to move, cycles waited.
    int         m_owner, m_left, m_wait, m_rr, m_done_total = 0;
    bit         m_fresh, m_closing, m_err, m_ldrst;
    logic [7:0] m_tiles;

    logic [WD-1:0] rx[$];
    int            glog[$];
    int            rst_pulses, err_cyc, last_xfer_cyc, bad_r1;
    bit            prev_err = 1'b0;
    logic [NR-1:0] prev_grant = '0;

    function automatic logic [WD-1:0] pat(int r, int k);
        return (WD'(r) << 64) | (WD'(k) << 4) | WD'(9);
    endfunction

    function automatic logic [WD-1:0] rnd_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[WD-1:0];
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_wait = 0; m_rr = 0;
        m_fresh = 1'b0; m_closing = 1'b0; m_err = 1'b0; m_ldrst = 1'b1;
        m_tiles = 8'd0;
    endtask

    task automatic model_close();
        m_closing = 1'b1;
        m_rr      = (m_owner + 1) % NR;
        m_owner   = -1;
    endtask

    task automatic model_step();
        if (m_closing) begin
            m_tiles = m_tiles + 8'd1;
            m_done_total++;
            m_closing = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = NR - 1; k >= 0; k--) begin
                if (req_v_i[(m_rr + k) % NR]) m_owner = (m_rr + k) % NR;
            end
            if (m_owner >= 0) begin
                m_fresh = 1'b1;
                m_left  = TILE;
            end
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (m_left > 0) begin
            if (req_v_i[m_owner] && ld_r_i) begin
                m_left--;
                if (m_left == 0) m_wait = 0;
            end
        end else begin
            if (ld_done_i) begin
                model_close();
            end else if (m_wait == TO - 1) begin
                m_err = 1'b1;
                model_close();
            end else begin
                m_wait++;
            end
        end
        m_ldrst = m_fresh;
    endtask

    task automatic drive();
        bit v, waiting;
        for (int r = 0; r < NR; r++) begin
            v = (src_word[r] < src_limit[r]) && !(gap_on && ($urandom_range(2) == 0));
            req_v_i[r]    = v;
            req_data_i[r] = v ? pat(r, src_word[r]) : rnd_word();
        end
        case (ldr_mode)
            0:       ld_r_i = 1'b1;
            1:       ld_r_i = (cyc % 2 == 0);
            default: ld_r_i = 1'($urandom_range(1));
        endcase
        waiting = (m_owner >= 0) && !m_fresh && (m_left == 0);
        if (waiting) ld_done_i = (done_delay >= 0) && (m_wait == done_delay);
        else         ld_done_i = spurious && ($urandom_range(3) == 0);
    endtask

    always @(posedge clk) begin
        for (int r = 0; r < NR; r++) if (hs[r]) src_word[r]++;
        if (rst_ni) model_step();
        cyc++;
        #1 drive();
    end

    always @(negedge clk) begin
        logic [NR-1:0] e_oh, e_grant, e_rr;
        logic [WD-1:0] e_bit;
        bit            streaming, e_ldv;
        if (!rst_ni) model_reset();
        e_oh = '0;
        if (m_owner >= 0) e_oh[m_owner] = 1'b1;
        streaming = (m_owner >= 0) && !m_fresh && (m_left > 0);
        e_ldv     = streaming && req_v_i[m_owner];
        e_bit     = e_ldv ? req_data_i[m_owner] : '0;
        e_rr      = (streaming && ld_r_i) ? e_oh : '0;
        e_grant   = e_oh;
        chk("grant_o",    grant_o,    e_grant);
        chk("busy_o",     busy_o,     (m_owner >= 0) || m_closing);
        chk("ld_v_o",     ld_v_o,     e_ldv);
        chk("ld_bit_o",   ld_bit_o,   e_bit);
        chk("req_r_o",    req_r_o,    e_rr);
        chk("ld_rst_o",   ld_rst_o,   m_ldrst);
        chk("tile_cnt_o", tile_cnt_o, m_tiles);
        chk("err_o",      err_o,      m_err);
        hs = req_v_i & req_r_o;
        if (ld_v_o && ld_r_i) begin
            rx.push_back(ld_bit_o);
            last_xfer_cyc = cyc;
        end
        if (grant_o != '0 && prev_grant == '0) begin
            for (int r = 0; r < NR; r++) if (grant_o[r]) glog.push_back(r);
        end
        prev_grant = grant_o;
        if (err_o && !prev_err) err_cyc = cyc;
        prev_err = err_o;
        if (ld_rst_o) rst_pulses++;
        if (grant_o == NR'(1) && req_r_o[1]) bad_r1++;
    end

    task automatic wait_tiles(int n, int bound);
        int target, c;
        target = m_done_total + n;
        c = 0;
        while (m_done_total < target && c < bound) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (m_done_total < target) begin
            n_err++;
            $display("FAIL wait_tiles: got %0d tiles expected %0d within %0d cycles",
                     m_done_total - target + n, n, bound);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_ni = 1'b0;
        for (int r = 0; r < NR; r++) begin
            src_word[r]  = 0;
            src_limit[r] = 0;
        end
        #1;
        chk("rst_grant",  grant_o,    '0);
        chk("rst_busy",   busy_o,     1'b0);
        chk("rst_ld_v",   ld_v_o,     1'b0);
        chk("rst_ld_bit", ld_bit_o,   '0);
        chk("rst_req_r",  req_r_o,    '0);
        chk("rst_tile",   tile_cnt_o, 8'd0);
        chk("rst_err",    err_o,      1'b0);
        chk("rst_ld_rst", ld_rst_o,   1'b1);
        glog.delete();
        rx.delete();
        repeat (2) @(posedge clk);
        #3 rst_ni = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        int tbase;
        exp_g = '{0, 1, 0, 1};
        for (int r = 0; r < NR; r++) begin
            src_word[r]  = 0;
            src_limit[r] = 0;
        end
        model_reset();
        rst_ni = 1'b0; req_v_i = '0; req_data_i = '0; ld_r_i = 1'b0; ld_done_i = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // Single requester, always-ready loader, done three cycles after the tile.
        rst_pulses = 0; rx.delete(); done_delay = 2;
        src_limit[0] = TILE;
        wait_tiles(1, 200);
        chk("t1_tile_cnt", tile_cnt_o, 8'd1);
        chk("t1_grant",    grant_o,    '0);
        chk("t1_busy",     busy_o,     1'b0);
        chk("t1_rst_pulses", rst_pulses, 1);
        chk("t1_words", rx.size(), TILE);
        for (int i = 0; i < TILE && i < rx.size(); i++) chk("t1_word", rx[i], pat(0, i));

        // Both requesters valid from reset: alternate ownership.
        do_reset();
        done_delay = 0;
        src_limit[0] = 2 * TILE; src_limit[1] = 2 * TILE;
        wait_tiles(4, 400);
        chk("t2_tile_cnt", tile_cnt_o, 8'd4);
        chk("t2_grants", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("t2_grant_order", glog[i], exp_g[i]);

        // Toggling loader ready and requester gaps.
        rx.delete(); bad_r1 = 0; gap_on = 1'b1; ldr_mode = 1;
        tbase = src_word[0];
        src_limit[0] = src_word[0] + TILE; src_limit[1] = src_word[1] + TILE;
        wait_tiles(2, 600);
        chk("t3_words", rx.size(), 2 * TILE);
        for (int i = 0; i < TILE && i < rx.size(); i++) chk("t3_word_r0", rx[i], pat(0, tbase + i));
        chk("t3_r1_ready", bad_r1, 0);
        chk("t3_tile_cnt", tile_cnt_o, 8'd6);

        // Loader never reports done: timeout after TO cycles of waiting.
        gap_on = 1'b0; ldr_mode = 0; done_delay = -1;
        src_limit[0] = src_word[0] + TILE; src_limit[1] = src_word[1] + TILE;
        wait_tiles(1, 300);
        chk("t4_err", err_o, 1'b1);
        chk("t4_err_latency", err_cyc - (last_xfer_cyc + 1), TO);
        chk("t4_tile_cnt", tile_cnt_o, 8'd7);
        done_delay = 1;
        wait_tiles(1, 300);
        chk("t4_next_tile_cnt", tile_cnt_o, 8'd8);
        chk("t4_err_sticky", err_o, 1'b1);
        chk("t4_next_owner", glog[glog.size() - 1], 1);

        // Reset in the middle of a tile.
        done_delay = 0; rx.delete();
        src_limit[0] = src_word[0] + 2 * TILE;
        begin
            int c;
            c = 0;
            while (rx.size() < 8 && c < 200) begin
                @(posedge clk);
                c++;
            end
            chk("t5_words_before_reset", rx.size(), 8);
        end
        do_reset();
        src_limit[0] = TILE; src_limit[1] = TILE;
        wait_tiles(1, 200);
        chk("t5_first_owner", glog.size() > 0 ? glog[0] : -1, 0);
        chk("t5_tile_cnt", tile_cnt_o, 8'd1);
        chk("t5_words", rx.size() >= TILE, 1'b1);
        for (int i = 0; i < TILE && i < rx.size(); i++) chk("t5_word", rx[i], pat(0, i));

        // Run the counter up to 255 with random ready and stray done pulses, then wrap.
        ldr_mode = 2; spurious = 1'b1;
        src_limit[0] = 32'h3fff_ffff; src_limit[1] = 32'h3fff_ffff;
        wait_tiles(254, 40000);
        chk("t6_tile_255", tile_cnt_o, 8'd255);
        wait_tiles(1, 300);
        chk("t6_tile_wrap", tile_cnt_o, 8'd0);
        src_limit[0] = 0; src_limit[1] = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tile_load_arbiter.md
TILE_LOAD_ARBITER -- requirements
Module: tile_load_arbiter

Interface
REQ-001 Parameter Dim, default 4, systolic array dimension; one tile is Dim*Dim words.
REQ-002 Parameter W, default 77, word width.
REQ-003 Parameter NREQ, default 2, number of requesters (2..4).
REQ-004 Parameter TMO, default 64, cycles allowed between tile end and ld_done_i.
REQ-005 clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 req_v_i  in  NREQ  per-requester word valid.
REQ-008 req_data_i  in  NREQ x W  per-requester word.
REQ-009 req_r_o  out  NREQ  per-requester ready.
REQ-010 ld_bit_o  out  W  word to column loader.
REQ-011 ld_v_o  out  1  word valid to loader.
REQ-012 ld_r_i  in  1  loader ready.
REQ-013 ld_done_i  in  1  loader finished all Dim columns.
REQ-014 ld_rst_o  out  1  active-high synchronous restart to loader.
REQ-015 grant_o  out  NREQ  one-hot current owner; all-zero when unowned.
REQ-016 busy_o  out  1  high in any state except IDLE.
REQ-017 tile_cnt_o  out  8  completed tiles, wraps 255->0.
REQ-018 err_o  out  1  sticky loader-timeout flag.

Function
REQ-019 States IDLE, START, STREAM, WAIT_DONE, RELEASE; encoding free.
REQ-020 IDLE: when any req_v_i high, grant first requester with valid scanning upward from rr_ptr modulo NREQ; latch grant, go START; else stay.
REQ-021 Simultaneous valids: rr_ptr alone decides; non-granted requesters see req_r_o=0.
REQ-022 START: ld_rst_o=1 for exactly one cycle, word_cnt cleared, go STREAM; req_r_o all 0.
REQ-023 STREAM: ld_bit_o = req_data_i[g], ld_v_o = req_v_i[g], req_r_o[g] = ld_r_i; other req_r_o 0; combinational pass-through, zero latency.
REQ-024 Transfer = ld_v_o & ld_r_i; each transfer increments word_cnt (width $clog2(Dim*Dim+1)).
REQ-025 Transfer bringing word_cnt to Dim*Dim moves to WAIT_DONE; no further words forwarded (ld_v_o=0, req_r_o=0) until next grant.
REQ-026 Requester dropping valid mid-tile holds grant; STREAM waits indefinitely, no preemption.
REQ-027 WAIT_DONE: timeout counter counts up from 0; ld_done_i=1 -> RELEASE; counter reaching TMO-1 without ld_done_i -> set err_o, go RELEASE.
REQ-028 RELEASE (one cycle): tile_cnt_o += 1, rr_ptr = (g+1) mod NREQ, grant_o cleared, go IDLE.
REQ-029 ld_done_i outside WAIT_DONE ignored.
REQ-030 grant_o one-hot in START, STREAM, WAIT_DONE; zero in IDLE and RELEASE.
REQ-031 ld_bit_o = 0 whenever ld_v_o = 0.
REQ-032 err_o clears only on reset.

Reset
REQ-033 rst_ni low asynchronously forces IDLE; rr_ptr=0, word_cnt=0, timeout counter=0, tile_cnt_o=0, err_o=0, grant_o=0, busy_o=0, req_r_o=0, ld_v_o=0, ld_bit_o=0.
REQ-034 ld_rst_o = 1 while rst_ni low, so loader is held in reset; deasserts at first rising edge after rst_ni rises.
REQ-035 Reset mid-STREAM abandons partial tile; no tile_cnt_o increment; next tile restarts via START.

Verification
REQ-036 Single requester 0, ld_r_i=1, 16 consecutive words -> ld_rst_o pulse 1 cycle, 16 transfers, ld_done_i 3 cycles later -> tile_cnt_o=1, grant_o=0, busy_o=0.
REQ-037 Both requesters valid from reset -> tiles granted order 0,1,0,1; grant_o never changes mid-tile; tile_cnt_o=4 after four tiles.
REQ-038 ld_r_i toggled 1/0 every cycle plus requester valid gaps -> exactly 16 words in order, no duplicates, none lost; req_r_o[1]=0 throughout requester 0 tile.
REQ-039 ld_done_i withheld, TMO=64 -> err_o=1 exactly 64 cycles into WAIT_DONE, tile_cnt_o increments, next grant proceeds, err_o stays 1.
REQ-040 rst_ni pulled low after word 7 -> all outputs at reset values immediately, ld_rst_o=1; after release, requester 0 granted first, 16 fresh words.
REQ-041 tile_cnt_o at 255, one tile completed -> tile_cnt_o=0.
